// File: rtl/button_debouncer.sv
// N-channel push-button front end: 2-flop synchroniser, tick-sampled debounce,
// press/release edge pulses and a one-shot long-press pulse per channel.
module button_debouncer #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned TICK_HZ        = 1_000,
  parameter int unsigned N_BTN          = 4,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned HOLD_TICKS     = 1000,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold,
  output logic             tick
);

  localparam int unsigned TickDiv = (TICK_HZ == 0) ? 0 : CLK_FREQ / TICK_HZ;
  localparam int unsigned CntW    = (TickDiv > 2) ? $clog2(TickDiv) : 1;
  localparam int unsigned DcntW   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  // Extra code point HOLD_TICKS marks "already fired" until release.
  localparam int unsigned HcntW   = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(TickDiv - 1);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_TICKS - 1);
  localparam logic [HcntW-1:0] HcntLast = HcntW'(HOLD_TICKS - 1);
  localparam logic [HcntW-1:0] HcntSat  = HcntW'(HOLD_TICKS);
  localparam logic [N_BTN-1:0] IdlePins = {N_BTN{ACTIVE_LOW}};

  if (TICK_HZ < 1 || TickDiv < 2 || DEBOUNCE_TICKS < 1 || HOLD_TICKS < 1 || N_BTN < 1)
  begin : g_param_check
    $error("button_debouncer: illegal parameter combination");
  end

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_BTN-1:0] sync1_q, sync2_q, s;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] hold_q, hold_d;
  logic [DcntW-1:0] dcnt_q [N_BTN];
  logic [DcntW-1:0] dcnt_d [N_BTN];
  logic [HcntW-1:0] hcnt_q [N_BTN];
  logic [HcntW-1:0] hcnt_d [N_BTN];

  assign tick = (cnt_q == CntLast);
  assign s    = sync2_q ^ IdlePins;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (tick) cnt_d = '0;
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      dcnt_d[i] = dcnt_q[i];
      hcnt_d[i] = hcnt_q[i];

      if (s[i] == level_q[i]) begin
        dcnt_d[i] = '0;
      end else if (tick) begin
        if (dcnt_q[i] == DcntLast) begin
          level_d[i] = ~level_q[i];
          dcnt_d[i]  = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DcntW'(1);
        end
      end

      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];

      // A release accepted on the same tick suppresses the hold pulse.
      if (!level_q[i]) begin
        hcnt_d[i] = '0;
      end else if (tick && hcnt_q[i] != HcntSat) begin
        if (hcnt_q[i] == HcntLast) begin
          hold_d[i] = level_d[i];
          hcnt_d[i] = HcntSat;
        end else begin
          hcnt_d[i] = hcnt_q[i] + HcntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      sync1_q   <= IdlePins;
      sync2_q   <= IdlePins;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        dcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        dcnt_q[i] <= dcnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_hold    = hold_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-high and an active-low instance checked every cycle
// against a run-length/tick-arithmetic reference model, plus directed scenario checks.
module tb_button_debouncer;
  localparam int D  = 10;
  localparam int DB = 3;
  localparam int H  = 5;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] in_a, in_b;
  logic [N-1:0] lvl_a, pr_a, rl_a, hd_a, lvl_b, pr_b, rl_b, hd_b;
  logic tick_a, tick_b;

  always #5 clk = ~clk;

  button_debouncer #(.CLK_FREQ(1000), .TICK_HZ(100), .N_BTN(N), .DEBOUNCE_TICKS(DB),
                     .HOLD_TICKS(H), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .btn_in(in_a), .btn_level(lvl_a), .btn_press(pr_a),
    .btn_release(rl_a), .btn_hold(hd_a), .tick(tick_a));

  button_debouncer #(.CLK_FREQ(1000), .TICK_HZ(100), .N_BTN(N), .DEBOUNCE_TICKS(DB),
                     .HOLD_TICKS(H), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .btn_in(in_b), .btn_level(lvl_b), .btn_press(pr_b),
    .btn_release(rl_b), .btn_hold(hd_b), .tick(tick_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: level accepted once DB ticks fall inside an unbroken mismatch run;
  // hold fires on the H-th tick counted from the first cycle the level is 1.
  int          cyc;
  bit [N-1:0]  h1 [2];
  bit [N-1:0]  h2 [2];
  bit [N-1:0]  m_lvl [2];
  bit [N-1:0]  m_pr [2];
  bit [N-1:0]  m_rl [2];
  bit [N-1:0]  m_hd [2];
  int          m_run [2][N];
  int          m_rise [2][N];

  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / D - a / D;
  endfunction

  always @(negedge clk) begin
    bit [N-1:0] s;
    bit [N-1:0] pin;
    bit         tk;
    bit         cur, nxt;
    if (rst) begin
      check_eq("rst_level", {lvl_b, lvl_a}, 0);
      check_eq("rst_pulses", {pr_b, rl_b, hd_b, pr_a, rl_a, hd_a}, 0);
      check_eq("rst_tick", {tick_b, tick_a}, 0);
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        h1[k] = '0; h2[k] = '0;
        m_lvl[k] = '0; m_pr[k] = '0; m_rl[k] = '0; m_hd[k] = '0;
        for (int i = 0; i < N; i++) begin
          m_run[k][i] = -1;
          m_rise[k][i] = 0;
        end
      end
    end else begin
      tk = (cyc % D) == D - 1;
      check_eq("level", lvl_a, m_lvl[0]);
      check_eq("press", pr_a, m_pr[0]);
      check_eq("release", rl_a, m_rl[0]);
      check_eq("hold", hd_a, m_hd[0]);
      check_eq("tick", tick_a, tk);
      check_eq("al_level", lvl_b, m_lvl[1]);
      check_eq("al_press", pr_b, m_pr[1]);
      check_eq("al_release", rl_b, m_rl[1]);
      check_eq("al_hold", hd_b, m_hd[1]);
      check_eq("al_tick", tick_b, tk);
      for (int k = 0; k < 2; k++) begin
        s = h2[k];
        for (int i = 0; i < N; i++) begin
          cur = m_lvl[k][i];
          nxt = cur;
          if (s[i] == cur) begin
            m_run[k][i] = -1;
          end else begin
            if (m_run[k][i] < 0) m_run[k][i] = cyc;
            if (tk && ticks_in(m_run[k][i], cyc) == DB) begin
              nxt = ~cur;
              m_run[k][i] = -1;
            end
          end
          m_hd[k][i] = cur && nxt && tk && ticks_in(m_rise[k][i], cyc) == H;
          m_pr[k][i] = nxt & ~cur;
          m_rl[k][i] = cur & ~nxt;
          if (nxt & ~cur) m_rise[k][i] = cyc + 1;
          m_lvl[k][i] = nxt;
        end
        pin = (k == 0) ? in_a : ~in_b;
        h2[k] = h1[k];
        h1[k] = pin;
      end
      cyc++;
    end
  end

  int n_press [N];
  int n_rel [N];
  int n_hold [N];
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        n_press[i] += int'(pr_a[i]);
        n_rel[i]   += int'(rl_a[i]);
        n_hold[i]  += int'(hd_a[i]);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after a drive; lat = negedges until press on ch (0 = same cycle), -1 on timeout.
  task automatic wait_press(input int ch, input int max, output int lat);
    lat = -1;
    for (int n = 0; n <= max; n++) begin
      @(negedge clk);
      if (pr_a[ch]) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, nt, p0, h0;
    for (int i = 0; i < N; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_hold[i] = 0;
    end
    rst = 1'b1; in_a = '0; in_b = '1;
    cycles(3);
    rst = 1'b0;

    // Idle with active-low pins high: tick every 10th cycle, nothing pressed.
    nt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      nt += int'(tick_a);
    end
    check_eq("idle_tick_count", nt, 3);
    check_eq("idle_al_level", lvl_b, 0);
    cycles(1);

    // Single clean press on ch0 (and an active-low press on ch2 of the second instance).
    in_a[0] = 1'b1;
    in_b[2] = 1'b0;
    wait_press(0, 40, lat);
    check_eq("press_latency_ok", (lat >= 21 && lat <= 32), 1);
    check_eq("press_other_ch", lvl_a[3:1], 0);
    cycles(40);
    check_eq("al_press_level", lvl_b, 4'b0100);
    in_a[0] = 1'b0;
    in_b[2] = 1'b1;
    cycles(40);

    // Bounce on ch1: toggle every 7 cycles, then settle high.
    p0 = n_press[1];
    for (int j = 0; j < 10; j++) begin
      in_a[1] = ~in_a[1];
      cycles(7);
    end
    check_eq("bounce_no_press", n_press[1] - p0, 0);
    in_a[1] = 1'b1;
    wait_press(1, 40, lat);
    check_eq("bounce_latency_ok", (lat >= 21 && lat <= 32), 1);
    cycles(40);
    check_eq("bounce_one_press", n_press[1] - p0, 1);

    // 15-cycle glitch on ch2 is rejected.
    p0 = n_press[2];
    in_a[2] = 1'b1;
    cycles(15);
    in_a[2] = 1'b0;
    cycles(40);
    check_eq("glitch_no_press", n_press[2] - p0, 0);
    check_eq("glitch_no_release", n_rel[2], 0);
    check_eq("glitch_level", lvl_a[2], 0);

    // Long press on ch3, twice.
    h0 = n_hold[3];
    in_a[3] = 1'b1;
    cycles(120);
    check_eq("hold_once", n_hold[3] - h0, 1);
    in_a[3] = 1'b0;
    cycles(40);
    check_eq("hold_release", n_rel[3], 1);
    in_a[3] = 1'b1;
    cycles(120);
    in_a[3] = 1'b0;
    cycles(40);
    check_eq("hold_rearm", n_hold[3] - h0, 2);

    in_a = '0;
    cycles(40);

    // Reset in the middle of a ch0 debounce while ch1 is held.
    in_a[1] = 1'b1;
    cycles(40);
    in_a[0] = 1'b1;
    nt = 0;
    for (int n = 0; n < 40 && nt < 2; n++) begin
      @(negedge clk);
      if (n >= 2 && tick_a) nt++;
    end
    check_eq("mid_debounce_ch0", {nt[1:0], lvl_a[0]}, 3'b100);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_level", lvl_a, 0);
    check_eq("async_rst_pulses", {pr_a, rl_a, hd_a, tick_a}, 0);
    cycles(3);
    rst = 1'b0;
    wait_press(0, 40, lat);
    check_eq("rst_redebounce_latency", lat, 30);
    check_eq("rst_press_coincide", pr_a, 4'b0011);
    cycles(10);

    // Random phase on both instances with one asynchronous reset.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 29) == 0) in_a[i] = ~in_a[i];
        if ($urandom_range(0, 29) == 0) in_b[i] = ~in_b[i];
      end
      if (n == 1000) rst = 1'b1;
      if (n == 1002) rst = 1'b0;
      cycles(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
